// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: double-buffered N-digit seven-segment scan driver with one-hot anodes, optional blink (SEG7_BLINK_EN).
// Ports: clk, rst_n (async active-low) | digits_in/dp_in/blank_in/blink_in captured on load into a shadow register,
// copied to the active register at frame start | hex_mode live A-F enable | seg_out {a..g}, dp_out, an_out one-hot,
// frame_start pulse. ACTIVE_LOW inverts all display pins. SEG7_BLINK_EN builds the blink-phase frame counter.
module seg7_scan_mux #(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 1000,
  parameter int ACTIVE_LOW   = 0,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic                    hex_mode,
  input  logic                    load,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_start
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = 7*NUM_DIGITS;
  localparam int N  = NUM_DIGITS;
  logic [PW-1:0] presc;
  logic [IW-1:0] idx, nidx;
  logic [DW-1:0] sh, ac, ac_n;
  logic [N-1:0] dp_v, blank_v, blink_v;
  logic [3:0] code;
  logic [6:0] seg_d, seg_q;
  logic tick, frame, blanked, dp_q, fs_q;
  logic [N-1:0] an_q;
  assign tick    = presc == PW'(SCAN_DIV-1);
  assign nidx    = idx == IW'(N-1) ? '0 : idx + 1'b1;
  assign frame   = tick && nidx == '0;
  // outputs on a tick edge must reflect the active data as it will be after that edge
  assign ac_n    = frame ? sh : ac;
  assign code    = ac_n[4*nidx +: 4];
  assign dp_v    = ac_n[5*N-1:4*N];
  assign blank_v = ac_n[6*N-1:5*N];
  assign blink_v = ac_n[7*N-1:6*N];
`ifdef SEG7_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES+1);
  logic [FW-1:0] fcnt;
  logic boff, boff_n;
  // fcnt counts frames spent in the current phase; the phase flips on the frame start after BLINK_FRAMES of them
  assign boff_n  = frame && fcnt == FW'(BLINK_FRAMES) ? ~boff : boff;
  assign blanked = blank_v[nidx] | (boff_n & blink_v[nidx]);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fcnt <= '0;
      boff <= 1'b0;
    end else if (frame) begin
      fcnt <= fcnt == FW'(BLINK_FRAMES) ? FW'(1) : fcnt + 1'b1;
      boff <= boff_n;
    end
`else
  logic unused_blink;
  assign blanked      = blank_v[nidx];
  assign unused_blink = ^{blink_v, BLINK_FRAMES[0]};
`endif
  always_comb begin
    seg_d = 7'b0000000;
    case (code)
      4'h0: seg_d = 7'b1111110;
      4'h1: seg_d = 7'b0110000;
      4'h2: seg_d = 7'b1101101;
      4'h3: seg_d = 7'b1111001;
      4'h4: seg_d = 7'b0110011;
      4'h5: seg_d = 7'b1011011;
      4'h6: seg_d = 7'b1011111;
      4'h7: seg_d = 7'b1110010;
      4'h8: seg_d = 7'b1111111;
      4'h9: seg_d = 7'b1111011;
      4'hA: seg_d = 7'b1110111;
      4'hB: seg_d = 7'b0011111;
      4'hC: seg_d = 7'b1001110;
      4'hD: seg_d = 7'b0111101;
      4'hE: seg_d = 7'b1001111;
      4'hF: seg_d = 7'b1000111;
      default: seg_d = 7'b0000000;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      presc <= '0;
      idx   <= IW'(N-1);
      sh    <= '0;
      ac    <= '0;
      seg_q <= '0;
      dp_q  <= 1'b0;
      an_q  <= '0;
      fs_q  <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      fs_q  <= frame;
      if (load) sh <= {blink_in, blank_in, dp_in, digits_in};
      if (tick) begin
        idx   <= nidx;
        ac    <= ac_n;
        seg_q <= blanked || (code > 4'd9 && !hex_mode) ? 7'b0000000 : seg_d;
        dp_q  <= !blanked && dp_v[nidx];
        an_q  <= N'(1) << nidx;
      end
    end
  assign seg_out     = ACTIVE_LOW != 0 ? ~seg_q : seg_q;
  assign dp_out      = ACTIVE_LOW != 0 ? ~dp_q : dp_q;
  assign an_out      = ACTIVE_LOW != 0 ? ~an_q : an_q;
  assign frame_start = fs_q;
endmodule
